// File: rtl/frame_loader_pkg.sv
// Shared display geometry for the 80x80 frame buffer, plus loader state encoding.
// The VGA read side imports the same constants so both sides agree on the column-major map.
package frame_loader_pkg;

    localparam int DISP_W = 80;
    localparam int DISP_H = 80;
    localparam int DISP_ADDR_W = 13;
    localparam logic [7:0] DISP_SYNC = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 8-bit luminance down to the 2-bit gray level held in data[1:0].
    function automatic logic [7:0] quantize_luma(input logic [7:0] luma);
        return {6'b0, luma[7:6]};
    endfunction

endpackage

// File: rtl/frame_loader_addr_gen.sv
// Column-major write-address walker: addr tracks col*IMG_H + row using adds only.
// Pixels arrive in raster order, so each step moves one column right (addr += IMG_H).
module loader_addr_gen #(
    parameter int IMG_W  = 80,
    parameter int IMG_H  = 80,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_H);

    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (start_i) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (step_i) begin
            if (col_q != COL_LAST) begin
                col_d  = col_q + ADDR_W'(1);
                addr_d = addr_q + ROW_STRIDE;
            end else begin
                // Wrapping to column 0 of the next row lands on address row+1.
                col_d  = '0;
                row_d  = row_q + ADDR_W'(1);
                addr_d = row_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/frame_loader.sv
// Write side of the display path: waits for a sync byte, then stores one transposed frame.
// Handshake: a byte transfers on a rising edge where in_valid && in_ready; in_ready drops only in DONE.
module frame_loader
    import frame_loader_pkg::*;
#(
    parameter int         IMG_W     = DISP_W,
    parameter int         IMG_H     = DISP_H,
    parameter int         ADDR_W    = DISP_ADDR_W,
    parameter logic [7:0] SYNC_BYTE = DISP_SYNC,
    parameter int         TIMEOUT   = 1048576,
    parameter int         QUANTIZE  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              error,
    output state_t            dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Abort when the counter would step onto TIMEOUT-1 with no transfer.
    localparam logic [CNT_W-1:0] CNT_ABORT = CNT_W'(TIMEOUT - 2);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  idle_q, idle_d;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        wdata_q;
    logic              err_q, err_d;
    logic              xfer;
    logic              start;
    logic              step;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_last;
    logic [7:0]        pix;

    assign in_ready = (state_q != ST_DONE);
    assign xfer     = in_valid && in_ready;
    assign pix      = (QUANTIZE != 0) ? quantize_luma(in_data) : in_data;

    loader_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .start_i(start),
        .step_i (step),
        .addr_o (gen_addr),
        .last_o (gen_last)
    );

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        start   = 1'b0;
        step    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer && (in_data == SYNC_BYTE)) begin
                    state_d = ST_LOAD;
                    start   = 1'b1;
                    idle_d  = '0;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    step   = 1'b1;
                    idle_d = '0;
                    if (gen_last) state_d = ST_DONE;
                end else if (idle_q == CNT_ABORT) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idle_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            we_q    <= step;
            err_q   <= err_d;
            if (step) begin
                waddr_q <= gen_addr;
                wdata_q <= pix;
            end
        end
    end

    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign busy       = (state_q == ST_LOAD);
    assign frame_done = (state_q == ST_DONE);
    assign error      = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: two instances (quantizing and raw) share one stream and are
// scored against expected writes computed from raster index k with plain arithmetic.
module tb_frame_loader;
  import frame_loader_pkg::*;

  localparam int W     = DISP_W;
  localparam int H     = DISP_H;
  localparam int AW    = DISP_ADDR_W;
  localparam int N_PIX = W * H;
  localparam int TMO   = 16;
  localparam int EW    = 1 + AW + 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready_qz, in_ready_rw;
  logic          we_qz, we_rw;
  logic [AW-1:0] waddr_qz, waddr_rw;
  logic [7:0]    wdata_qz, wdata_rw;
  logic          busy_qz, busy_rw;
  logic          frame_done_qz, frame_done_rw;
  logic          error_qz, error_rw;
  state_t        dbg_qz, dbg_rw;

  frame_loader #(.TIMEOUT(TMO), .QUANTIZE(1)) u_quant (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_qz),
    .we(we_qz), .waddr(waddr_qz), .wdata(wdata_qz), .busy(busy_qz),
    .frame_done(frame_done_qz), .error(error_qz), .dbg_state(dbg_qz)
  );

  frame_loader #(.TIMEOUT(TMO), .QUANTIZE(0)) u_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_rw),
    .we(we_rw), .waddr(waddr_rw), .wdata(wdata_rw), .busy(busy_rw),
    .frame_done(frame_done_rw), .error(error_rw), .dbg_state(dbg_rw)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  int wr_cnt = 0;
  int fd_cnt = 0;
  int err_cnt = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got 0x%0h, expected no such event", name, act);
  endtask

  // Monitor: samples registered outputs on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (we_qz || we_rw) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_write", 32'(waddr_qz));
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("we_quant", 32'(we_qz), 1);
          chk("we_raw", 32'(we_rw), 1);
          chk("waddr_quant", 32'(waddr_qz), 32'(e[AW+7:8]));
          chk("waddr_raw", 32'(waddr_rw), 32'(e[AW+7:8]));
          chk("wdata_quant", 32'(wdata_qz), 32'(e[7:0]) >> 6);
          chk("wdata_raw", 32'(wdata_rw), 32'(e[7:0]));
          chk("frame_done_quant", 32'(frame_done_qz), 32'(e[EW-1]));
          chk("frame_done_raw", 32'(frame_done_rw), 32'(e[EW-1]));
        end
      end else if (frame_done_qz || frame_done_rw) begin
        fail_now("frame_done_without_write", 32'(frame_done_qz));
      end
      if (error_qz && frame_done_qz) fail_now("error_with_frame_done", 32'(error_qz));
      if (frame_done_qz) fd_cnt++;
      if (error_qz) err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    while (!in_ready_qz && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready_qz) fail_now("in_ready_stuck_low", 32'(guard));
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // mode 0: byte k = k mod 256; mode 1: random bytes with pixel 1 forced to the sync value.
  task automatic send_pixels(input int n, input int mode, input bit gaps);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      int addr;
      if (mode == 0) b = 8'(k % 256);
      else if (k == 1) b = 8'hA5;
      else b = 8'($urandom_range(0, 255));
      addr = (k % W) * H + k / W;
      exp_q.push_back({(k == N_PIX - 1), AW'(addr), b});
      send_byte(b);
      if (gaps && k != n - 1 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, TMO - 2)) @(negedge clk);
    end
  endtask

  task automatic full_frame(input int mode, input bit gaps, input int frame_no);
    send_byte(8'hA5);
    chk("busy_after_sync", 32'(busy_qz), 1);
    send_pixels(N_PIX, mode, gaps);
    chk("done_in_ready_quant", 32'(in_ready_qz), 0);
    chk("done_in_ready_raw", 32'(in_ready_rw), 0);
    chk("done_busy", 32'(busy_qz), 0);
    chk("done_pulse", 32'(frame_done_rw), 1);
    @(negedge clk);
    chk("after_done_in_ready", 32'(in_ready_qz), 1);
    chk("after_done_pulse_low", 32'(frame_done_qz), 0);
    chk("frame_done_count", 32'(fd_cnt), 32'(frame_no));
    chk("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int i;
    bit found;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(we_qz), 0);
    chk("rst_in_ready", 32'(in_ready_qz), 1);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready_rw), 1);
    chk("reset_waddr", 32'(waddr_qz), 0);
    chk("reset_wdata", 32'(wdata_rw), 0);
    chk("reset_busy", 32'(busy_qz), 0);
    chk("reset_frame_done", 32'(frame_done_qz), 0);
    chk("reset_error", 32'(error_qz), 0);
    chk("reset_state", 32'(dbg_qz), 32'(ST_IDLE));

    // Pre-sync garbage is discarded.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    repeat (2) @(negedge clk);
    chk("garbage_no_writes", 32'(wr_cnt), 0);
    chk("garbage_not_busy", 32'(busy_qz), 0);

    full_frame(0, 1'b0, 1);
    full_frame(1, 1'b1, 2);
    chk("two_frames_writes", 32'(wr_cnt), 32'(2 * N_PIX));

    // Timeout after 10 pixels.
    send_byte(8'hA5);
    send_pixels(10, 1, 1'b0);
    i = 0;
    found = 1'b0;
    while (!found && i < 40) begin
      @(negedge clk);
      i++;
      if (error_qz) found = 1'b1;
    end
    chk("timeout_latency", 32'(i), TMO - 1);
    chk("timeout_error_raw", 32'(error_rw), 1);
    chk("timeout_busy_low", 32'(busy_qz), 0);
    chk("timeout_state_idle", 32'(dbg_rw), 32'(ST_IDLE));
    chk("timeout_writes", 32'(wr_cnt), 32'(2 * N_PIX + 10));
    chk("timeout_no_done", 32'(fd_cnt), 2);
    @(negedge clk);
    chk("error_one_cycle", 32'(error_qz), 0);
    chk("error_count", 32'(err_cnt), 1);
    send_byte(8'h11);
    repeat (2) @(negedge clk);
    chk("idle_after_timeout_no_write", 32'(wr_cnt), 32'(2 * N_PIX + 10));

    // Reset in the middle of a load.
    send_byte(8'hA5);
    send_pixels(100, 1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_we", 32'(we_qz), 0);
    chk("midrst_busy", 32'(busy_rw), 0);
    chk("midrst_waddr", 32'(waddr_qz), 0);
    chk("midrst_pending", 32'(exp_q.size()), 0);
    exp_q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    send_byte(8'h5A);
    repeat (2) @(negedge clk);
    chk("midrst_needs_sync", 32'(wr_cnt), 32'(2 * N_PIX + 110));
    full_frame(1, 1'b1, 3);
    chk("final_writes", 32'(wr_cnt), 32'(3 * N_PIX + 110));
    chk("final_errors", 32'(err_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
# frame_loader

Upstream write-side stage of the 80x80 display path. Accepts a raster-order byte stream (for example from a UART receiver), waits for a sync byte, then writes exactly one frame of pixels into the shared frame-buffer RAM. The VGA read side consumes that RAM in column-major order (address = column*IMG_H + row), so this block transposes addresses on the way in. It also optionally quantizes 8-bit luminance to the 2-bit gray code held in data[1:0].

## Interface
Parameters:
- IMG_W, 80, pixels per row (columns)
- IMG_H, 80, rows per frame
- ADDR_W, 13, frame-buffer address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W
- SYNC_BYTE, 8'hA5, start-of-frame marker
- TIMEOUT, 1048576, idle clocks allowed between bytes during a load before abort
- QUANTIZE, 1, when 1 store {6'b0, in_data[7:6]}; when 0 store in_data unchanged

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_data holds a byte this cycle
- in_data  in  8  stream byte
- in_ready  out  1  block accepts a byte this cycle; a byte transfers when in_valid && in_ready
- we  out  1  frame-buffer write enable
- waddr  out  ADDR_W  frame-buffer write address
- wdata  out  8  frame-buffer write data
- busy  out  1  high in LOAD
- frame_done  out  1  one-cycle pulse after the last pixel is written
- error  out  1  one-cycle pulse on timeout abort

## Operation
- States:
  - IDLE: in_ready=1. A transferred byte equal to SYNC_BYTE moves to LOAD; any other byte is discarded.
  - LOAD: in_ready=1. Each transferred byte becomes one pixel write.
  - DONE: in_ready=0 for exactly one cycle, frame_done=1, then IDLE.
- On entry to LOAD: col=0, row=0, addr=0, idle counter=0.
- Per transferred pixel in LOAD:
  - Issue a write at the current addr with the (quantized) byte.
  - If col < IMG_W-1: col++, addr += IMG_H.
  - Else: col=0, row++, addr = row+1 (the new row).
  - After the write at col=IMG_W-1, row=IMG_H-1, go to DONE.
- Address generation uses no multiplier; addr always equals col*IMG_H + row.
- In LOAD, a byte equal to SYNC_BYTE is ordinary pixel data. There is no resync mid-frame.
- Idle counter:
  - Cleared on every transfer in LOAD; increments on every other cycle in LOAD.
  - When it reaches TIMEOUT-1 without a transfer: go to IDLE, pulse error, write nothing further.
  - Pixels already written stay in RAM (partial frame).
- error and frame_done never assert in the same cycle.

## Timing
- Reset values: state=IDLE, in_ready=1, we=0, waddr=0, wdata=0, busy=0, frame_done=0, error=0, all counters 0.
- Write outputs are registered. A byte transferred in cycle N gives we=1 with its waddr/wdata in cycle N+1. we is high for one cycle per pixel. Back-to-back transfers give back-to-back writes.
- The last pixel's write (waddr=6399 at defaults) and the frame_done pulse are in the same cycle N+1. DONE occupies that cycle, so in_ready=0 in cycle N+1 and a byte offered then is not taken.
- busy rises the cycle after the sync byte transfers and falls in the DONE cycle.
- Timeout: error pulses the cycle after the counter reaches TIMEOUT-1; busy falls in that same cycle.
- rst asserted mid-load: all outputs return to reset values immediately, with no further writes. The next frame requires a new SYNC_BYTE.
- Throughput: one pixel per clock; one full frame is 1 + IMG_W*IMG_H transfers.

## Structure
- Shared display package holds IMG_W, IMG_H, ADDR_W and SYNC_BYTE, so this block and the VGA read side agree on geometry and address mapping.
- Sub-module loader_addr_gen: holds col, row and addr and the incremental column-major update. Inputs: start, step. Outputs: addr, last. The FSM, idle counter and output registers stay in frame_loader.

## Test plan
- Full frame at defaults: A5 then 6400 bytes, byte k = k mod 256, every cycle -> writes at waddr = (k mod 80)*80 + k/80, wdata = {6'b0, k[7:6]}, frame_done in the cycle of the 6400th write, then in_ready=0 for one cycle.
- Pre-sync garbage: 00, FF, 3C, then A5 and frame -> no writes before A5; first write at waddr=0.
- In-frame A5: pixel 1 = 8'hA5, QUANTIZE=0 -> write waddr=80, wdata=8'hA5, load continues.
- Bursty input: random in_valid gaps shorter than TIMEOUT (TIMEOUT=16) -> identical address/data sequence to the gapless case.
- Timeout: TIMEOUT=16, stop after 10 pixels -> exactly 10 writes, error pulse 16 cycles after the last transfer, state IDLE, no frame_done.
- Reset mid-load after 100 pixels -> we=0 and busy=0 immediately. A new A5 plus frame then writes starting at waddr=0.
